// File: rtl/cpu_defs.sv
// Shared CPU front-end definitions: fetch FSM encoding, boot vector and PC helpers.
package cpu_defs;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] CPU_RESET_PC = 32'hBFC0_0000;
  localparam int unsigned PC_STEP      = 4;

  function automatic logic pc_misaligned(input logic [1:0] pc_lo);
    return pc_lo != 2'b00;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: loads din when load is high, boots to RESET_PC.
module pc_reg
  import cpu_defs::*;
#(
  parameter int                 WIDTH    = 32,
  parameter logic [WIDTH-1:0]   RESET_PC = WIDTH'(CPU_RESET_PC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pc_q;

  // PC storage with synchronous reset to the boot vector
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (load) begin
      pc_q <= din;
    end
  end

  assign q = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: single-outstanding bus requests, redirect handling
// and a registered hand-off to decode.
module fetch_ctrl
  import cpu_defs::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(CPU_RESET_PC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exc_valid,
  input  logic [WIDTH-1:0] exc_pc,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             de_ready,
  output logic             inst_req,
  output logic [WIDTH-1:0] inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [WIDTH-1:0] inst_rdata,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_inst,
  output logic             if_adel
);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             if_valid_q, if_valid_d;
  logic [WIDTH-1:0] if_pc_q, if_pc_d;
  logic [WIDTH-1:0] if_inst_q, if_inst_d;
  logic             if_adel_q, if_adel_d;

  logic             pc_load_s;
  logic [WIDTH-1:0] pc_din_s;
  logic [WIDTH-1:0] pc_s;
  logic             redir_s;
  logic [WIDTH-1:0] redir_pc_s;
  logic             mis_s;
  logic             inst_req_s;

  pc_reg #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load_s),
    .din  (pc_din_s),
    .q    (pc_s)
  );

  // Redirect arbitration: exception beats branch
  always_comb begin
    redir_s    = exc_valid | br_valid;
    redir_pc_s = br_target;
    if (exc_valid) begin
      redir_pc_s = exc_pc;
    end else begin
      redir_pc_s = br_target;
    end
    mis_s = pc_misaligned(pc_s[1:0]);
  end

  // Next-state, PC update and decode hand-off
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_adel_d  = if_adel_q;
    pc_load_s  = 1'b0;
    pc_din_s   = redir_pc_s;
    inst_req_s = 1'b0;

    case (state_q)
      REQ: begin
        inst_req_s = ~mis_s;
        if (redir_s) begin
          // An accepted request must still drain its response before retargeting
          if (inst_addr_ok && !mis_s) begin
            pend_d  = redir_pc_s;
            state_d = DROP;
          end else begin
            pc_load_s = 1'b1;
          end
        end else if (mis_s) begin
          if_valid_d = 1'b1;
          if_adel_d  = 1'b1;
          if_pc_d    = pc_s;
          if_inst_d  = '0;
          state_d    = HOLD;
        end else if (inst_addr_ok) begin
          state_d = WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (redir_s) begin
          if (inst_data_ok) begin
            pc_load_s = 1'b1;
            state_d   = REQ;
          end else begin
            pend_d  = redir_pc_s;
            state_d = DROP;
          end
        end else if (inst_data_ok) begin
          if_valid_d = 1'b1;
          if_adel_d  = 1'b0;
          if_pc_d    = pc_s;
          if_inst_d  = inst_rdata;
          state_d    = HOLD;
        end else begin
          state_d = WAIT;
        end
      end
      HOLD: begin
        if (redir_s) begin
          pc_load_s  = 1'b1;
          if_valid_d = 1'b0;
          state_d    = REQ;
        end else if (de_ready) begin
          pc_load_s  = 1'b1;
          pc_din_s   = pc_s + WIDTH'(PC_STEP);
          if_valid_d = 1'b0;
          state_d    = REQ;
        end else begin
          state_d = HOLD;
        end
      end
      DROP: begin
        if (inst_data_ok) begin
          pc_load_s = 1'b1;
          if (redir_s) begin
            pc_din_s = redir_pc_s;
          end else begin
            pc_din_s = pend_q;
          end
          state_d = REQ;
        end else if (redir_s) begin
          pend_d = redir_pc_s;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = REQ;
      end
    endcase
  end

  // State, pending target and decode-facing registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= REQ;
      pend_q     <= '0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
      if_adel_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_adel_q  <= if_adel_d;
    end
  end

  assign inst_req  = inst_req_s;
  assign inst_addr = pc_s;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;
  assign if_adel   = if_adel_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized run
// against a program-flow reference model and a single-outstanding memory responder.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        exc_valid;
  logic [31:0] exc_pc;
  logic        br_valid;
  logic [31:0] br_target;
  logic        de_ready;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;

  int vecs;
  int errs;

  fetch_ctrl #(
    .WIDTH    (32),
    .RESET_PC (32'hBFC0_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .exc_valid    (exc_valid),
    .exc_pc       (exc_pc),
    .br_valid     (br_valid),
    .br_target    (br_target),
    .de_ready     (de_ready),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_adel      (if_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    exc_valid    = 1'b0;
    exc_pc       = 32'h0;
    br_valid     = 1'b0;
    br_target    = 32'h0;
    de_ready     = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    vecs++;
    if ({if_valid, if_adel, if_pc, if_inst} !== 66'h0) begin
      errs++;
      $display("FAIL reset_outputs: got valid=%b adel=%b pc=%h inst=%h, want all zero",
               if_valid, if_adel, if_pc, if_inst);
    end
    vecs++;
    if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0000) begin
      errs++;
      $display("FAIL reset_pc: got req=%b addr=%h, want req=1 addr=bfc00000", inst_req, inst_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp;
    for (int k = 0; k < 3; k++) begin
      exp = 32'hBFC0_0000 + 32'(4 * k);
      vecs++;
      if (inst_req !== 1'b1 || inst_addr !== exp) begin
        errs++;
        $display("FAIL seq_addr[%0d]: got req=%b addr=%h, want req=1 addr=%h", k, inst_req, inst_addr, exp);
      end
      inst_addr_ok = 1'b1;
      tick();
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b1;
      inst_rdata   = mem_word(exp);
      tick();
      inst_data_ok = 1'b0;
      vecs++;
      if (if_valid !== 1'b1 || if_pc !== exp || if_inst !== mem_word(exp)) begin
        errs++;
        $display("FAIL seq_deliver[%0d]: got valid=%b pc=%h inst=%h, want 1 %h %h",
                 k, if_valid, if_pc, if_inst, exp, mem_word(exp));
      end
      de_ready = 1'b1;
      tick();
      de_ready = 1'b0;
    end
  endtask

  task automatic test_branch_in_wait();
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    br_valid  = 1'b1;
    br_target = 32'h8000_1000;
    tick();
    br_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vecs++;
      if (if_valid !== 1'b0 || inst_req !== 1'b0) begin
        errs++;
        $display("FAIL br_wait_drop[%0d]: got valid=%b req=%b, want 0 0", k, if_valid, inst_req);
      end
      tick();
    end
    inst_data_ok = 1'b1;
    inst_rdata   = mem_word(32'hBFC0_000C);
    tick();
    inst_data_ok = 1'b0;
    vecs++;
    if (if_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h8000_1000) begin
      errs++;
      $display("FAIL br_wait_retarget: got valid=%b req=%b addr=%h, want 0 1 80001000",
               if_valid, inst_req, inst_addr);
    end
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = mem_word(32'h8000_1000);
    tick();
    inst_data_ok = 1'b0;
    vecs++;
    if (if_valid !== 1'b1 || if_pc !== 32'h8000_1000 || if_inst !== mem_word(32'h8000_1000)) begin
      errs++;
      $display("FAIL br_wait_deliver: got valid=%b pc=%h inst=%h, want 1 80001000 %h",
               if_valid, if_pc, if_inst, mem_word(32'h8000_1000));
    end
    de_ready = 1'b1;
    tick();
    de_ready = 1'b0;
  endtask

  task automatic test_exc_priority();
    exc_valid = 1'b1;
    exc_pc    = 32'hBFC0_0380;
    br_valid  = 1'b1;
    br_target = 32'h8000_2000;
    tick();
    clear_inputs();
    vecs++;
    if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0380) begin
      errs++;
      $display("FAIL exc_priority: got req=%b addr=%h, want 1 bfc00380", inst_req, inst_addr);
    end
  endtask

  task automatic test_hold_stall();
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = mem_word(32'hBFC0_0380);
    tick();
    inst_data_ok = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vecs++;
      if (if_valid !== 1'b1 || if_pc !== 32'hBFC0_0380 || if_inst !== mem_word(32'hBFC0_0380)
          || inst_req !== 1'b0 || if_adel !== 1'b0) begin
        errs++;
        $display("FAIL hold_stall[%0d]: got valid=%b pc=%h inst=%h req=%b adel=%b, want 1 bfc00380 %h 0 0",
                 k, if_valid, if_pc, if_inst, inst_req, if_adel, mem_word(32'hBFC0_0380));
      end
      tick();
    end
    de_ready = 1'b1;
    tick();
    de_ready = 1'b0;
    vecs++;
    if (if_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0384) begin
      errs++;
      $display("FAIL hold_release: got valid=%b req=%b addr=%h, want 0 1 bfc00384",
               if_valid, inst_req, inst_addr);
    end
  endtask

  task automatic test_misaligned();
    br_valid  = 1'b1;
    br_target = 32'h8000_0002;
    tick();
    br_valid = 1'b0;
    vecs++;
    if (inst_req !== 1'b0) begin
      errs++;
      $display("FAIL adel_no_req: got req=%b, want 0", inst_req);
    end
    tick();
    vecs++;
    if (if_valid !== 1'b1 || if_adel !== 1'b1 || if_pc !== 32'h8000_0002
        || if_inst !== 32'h0 || inst_req !== 1'b0) begin
      errs++;
      $display("FAIL adel_deliver: got valid=%b adel=%b pc=%h inst=%h req=%b, want 1 1 80000002 0 0",
               if_valid, if_adel, if_pc, if_inst, inst_req);
    end
    br_valid  = 1'b1;
    br_target = 32'h8000_0100;
    tick();
    br_valid = 1'b0;
    vecs++;
    if (if_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h8000_0100) begin
      errs++;
      $display("FAIL hold_redirect: got valid=%b req=%b addr=%h, want 0 1 80000100",
               if_valid, inst_req, inst_addr);
    end
  endtask

  task automatic test_reset_in_wait();
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    rst       = 1'b1;
    br_valid  = 1'b1;
    br_target = 32'h8000_3000;
    tick();
    rst      = 1'b0;
    br_valid = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hDEAD_BEEF;
    tick();
    inst_data_ok = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vecs++;
      if (if_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0000) begin
        errs++;
        $display("FAIL rst_in_wait[%0d]: got valid=%b req=%b addr=%h, want 0 1 bfc00000",
                 k, if_valid, inst_req, inst_addr);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] fpc;
    logic [31:0] oaddr;
    logic [31:0] tmp;
    logic [31:0] tgt;
    bit          outst;
    int          cnt;
    int          delivered;
    int          r;
    logic        s_req;
    logic        s_valid;
    logic [31:0] s_addr;
    logic [31:0] exp_inst;

    rst = 1'b1;
    clear_inputs();
    tick();
    rst       = 1'b0;
    fpc       = 32'hBFC0_0000;
    outst     = 1'b0;
    oaddr     = 32'h0;
    cnt       = 0;
    delivered = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      s_req   = inst_req;
      s_valid = if_valid;
      s_addr  = inst_addr;
      if (s_req) begin
        vecs++;
        if (s_addr !== fpc || outst || s_addr[1:0] !== 2'b00 || s_valid) begin
          errs++;
          $display("FAIL rnd_req@%0d: got addr=%h outstanding=%0b valid=%b, want addr=%h none 0",
                   cyc, s_addr, outst, s_valid, fpc);
        end
      end
      if (s_valid) begin
        exp_inst = (fpc[1:0] != 2'b00) ? 32'h0 : mem_word(fpc);
        vecs++;
        if (if_pc !== fpc || if_inst !== exp_inst || if_adel !== (fpc[1:0] != 2'b00)) begin
          errs++;
          $display("FAIL rnd_deliver@%0d: got pc=%h inst=%h adel=%b, want %h %h %b",
                   cyc, if_pc, if_inst, if_adel, fpc, exp_inst, fpc[1:0] != 2'b00);
        end
      end

      clear_inputs();
      inst_rdata   = $urandom;
      inst_data_ok = outst && (cnt == 0);
      if (inst_data_ok) inst_rdata = mem_word(oaddr);
      inst_addr_ok = s_req && !outst && ($urandom_range(0, 1) == 1);
      de_ready     = ($urandom_range(0, 9) < 6);
      r = $urandom_range(0, 99);
      tmp = $urandom;
      r = (r < 3) ? 2 : ((r < 9) ? 1 : 0);
      if (r != 0) begin
        case ($urandom_range(0, 15))
          0:       tgt = 32'hFFFF_FFF8;
          1:       tgt = {16'h8000, tmp[15:2], tmp[1:0] | 2'b01};
          default: tgt = {16'h8000, tmp[15:2], 2'b00};
        endcase
        if (r == 2) begin
          exc_valid = 1'b1;
          exc_pc    = tgt;
          if ($urandom_range(0, 1) == 1) begin
            br_valid  = 1'b1;
            br_target = tgt ^ 32'h0000_0040;
          end
        end else begin
          br_valid  = 1'b1;
          br_target = tgt;
        end
      end

      if (exc_valid)                 fpc = exc_pc;
      else if (br_valid)             fpc = br_target;
      else if (s_valid && de_ready) begin
        fpc = fpc + 32'd4;
        delivered++;
      end
      if (inst_data_ok) outst = 1'b0;
      else if (outst)   cnt--;
      if (inst_addr_ok) begin
        outst = 1'b1;
        oaddr = s_addr;
        cnt   = $urandom_range(0, 3);
      end
      tick();
    end
    clear_inputs();
    vecs++;
    if (delivered < 50) begin
      errs++;
      $display("FAIL rnd_progress: got %0d consumed instructions, want at least 50", delivered);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst  = 1'b1;
    clear_inputs();
    test_reset();
    test_sequential();
    test_branch_in_wait();
    test_exc_priority();
    test_hold_stall();
    test_misaligned();
    test_reset_in_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
